mnacidpro_seq: RTL and testbench
================================

Name: mnacidpro_seq

Overview:
- Protocol sequencer for the mnacidpro_pads nucleic-acid extraction chip.
- Drives the 11 valve control lines and the 3-phase peristaltic pump through a fixed run: bead load, lysis, bead trap, wash, elute, collect.
- Rotates the elution product across SIZE collect outlets, one outlet per run.
- Sits between the host/test controller and the chip's ctrl pads; its outputs map 1:1 to the chip's ctrl pad inputs.

Parameters:
- SIZE, 2, number of collect outlets (>=1).
- PUMP_DIV, 4, clocks per pump step (>=1).
- BEAD_STR, 4, pump strokes in BEAD.
- LYSIS_STR, 8, pump strokes in LYSIS.
- WASH_STR, 6, pump strokes in WASH.
- ELUTE_STR, 4, pump strokes in ELUTE.
- COLL_STR, 4, pump strokes in COLLECT.
- TRAP_CYC, 16, clocks in TRAP.
- FLUSH_CYC, 8, clocks per flush phase (feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; sampled in IDLE only
- abort  in  1  terminate run
- valve  out  11  valve ctrl, 1=closed. Bit map: 0 lysis, 1 wash, 2 elute, 3 dead_end, 4 vertical, 5 horiz, 6 waste, 7 bead, 8 loop_exit, 9 bead_trap, 10 collect.
- pump  out  3  pump valves, 1=closed
- collect_sel  out  CW  outlet for the current/next run; CW = max(1, clog2(SIZE))
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at run completion
- aborted  out  1  one-cycle pulse when abort takes effect

Behaviour:
- Reset values (asynchronous): state IDLE, valve=11'h7FF, pump=3'b111, collect_sel=0, busy=0, done=0, aborted=0. All outputs are registered.
- States and transitions:
  - IDLE -> BEAD -> LYSIS -> TRAP -> WASH -> ELUTE -> COLLECT -> DONE -> IDLE.
  - start=1 in IDLE enters BEAD on the next edge. Outputs reflect BEAD in that same cycle (one-cycle latency from start).
- Open valves per state; all other valves stay closed:
  - BEAD: bead, waste, bead_trap (valve=11'h53F).
  - LYSIS: lysis, horiz, dead_end (11'h7D6).
  - TRAP: bead_trap, loop_exit (11'h4FF).
  - WASH: wash, waste, bead_trap (11'h5BD).
  - ELUTE: elute, vertical, bead_trap (11'h5EB).
  - COLLECT: collect, loop_exit (11'h2FF).
  - IDLE and DONE: 11'h7FF.
- Pump:
  - Pumping states are BEAD, LYSIS, WASH, ELUTE and COLLECT.
  - In pumping states, pump cycles through a 6-step pattern: 011, 001, 101, 100, 110, 010.
  - The step advances every PUMP_DIV clocks. One stroke is 6 steps.
  - The step index and divider reset to 0 on every state entry.
  - A pumping state lasts exactly STR*6*PUMP_DIV clocks.
  - pump=3'b111 in TRAP, IDLE and DONE.
- TRAP lasts exactly TRAP_CYC clocks.
- DONE:
  - Lasts one cycle with done=1.
  - On exit, collect_sel increments and wraps from SIZE-1 to 0.
  - collect_sel is held constant for the whole run.
- abort:
  - Any non-IDLE state goes to IDLE on the next edge: valves all closed, pump 111, aborted=1 for one cycle, done=0.
  - collect_sel is unchanged.
  - abort in IDLE is a no-op.
  - If start and abort are both high in IDLE, abort wins and the block stays IDLE.
- start while busy is ignored.
- Duration counters are wide enough for the largest product; no overflow is permitted.
- Reset asserted mid-run returns all outputs to their reset values immediately (asynchronous), including collect_sel=0.

Optional Feature:
- Macro: MNACIDPRO_SEQ_FLUSH_EN.
- When defined:
  - Adds outputs flush[10:0] and pump_flush[2:0], both 1=active, both reset to 0.
  - After each of BEAD, LYSIS, WASH, ELUTE and COLLECT, a FLUSH phase of FLUSH_CYC clocks is inserted before the next state.
  - During FLUSH: valve=11'h7FF, pump=3'b111, flush = complement of the preceding state's valve pattern (pump_flush=3'b111 after pumping states).
  - abort during FLUSH returns to IDLE like any other state; flush clears with it.
- When undefined: no flush ports and no FLUSH phases; timing is exactly as described in Behaviour.

Test Plan:
- Reset then idle, no start -> valve=7FF, pump=111, busy=0, collect_sel=0 for 100 cycles.
- PUMP_DIV=2, BEAD_STR=1, start pulse -> next cycle valve=53F, pump=011. Pump steps every 2 clocks through 001, 101, 100, 110, 010. After 12 clocks valve=7D6.
- Full run, default params -> done pulses exactly once, 1 cycle, after 4*24+8*24+16+6*24+4*24+4*24 = 640 cycles of busy. collect_sel goes 0 -> 1. A second run wraps it to 0.
- abort at cycle 5 of WASH -> next cycle valve=7FF, pump=111, aborted=1, done never asserts, collect_sel unchanged. Then start works normally.
- start and abort high together in IDLE -> stays IDLE. start held high during a run -> no restart, total run length unchanged.
- With MNACIDPRO_SEQ_FLUSH_EN, FLUSH_CYC=8 -> after BEAD, 8 cycles with valve=7FF and flush=2C0, pump_flush=111, then LYSIS.

Source files
------------

// File: rtl/mnacidpro_seq.sv
// mnacidpro_seq: valve/pump run sequencer for the mnacidpro_pads chip.
// Ports: clk, rst_n, start, abort -> valve[10:0], pump[2:0], collect_sel, busy, done, aborted.
// Optional MNACIDPRO_SEQ_FLUSH_EN adds flush[10:0] and pump_flush[2:0] and FLUSH phases.
module mnacidpro_seq #(
  parameter int SIZE      = 2,
  parameter int PUMP_DIV  = 4,
  parameter int BEAD_STR  = 4,
  parameter int LYSIS_STR = 8,
  parameter int WASH_STR  = 6,
  parameter int ELUTE_STR = 4,
  parameter int COLL_STR  = 4,
  parameter int TRAP_CYC  = 16,
  parameter int FLUSH_CYC = 8,
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [10:0]   valve,
  output logic [2:0]    pump,
  output logic [CW-1:0] collect_sel,
  output logic          busy,
  output logic          done,
  output logic          aborted
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  ,
  output logic [10:0]   flush,
  output logic [2:0]    pump_flush
`endif
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int D_BEAD  = BEAD_STR * 6 * PUMP_DIV;
  localparam int D_LYSIS = LYSIS_STR * 6 * PUMP_DIV;
  localparam int D_WASH  = WASH_STR * 6 * PUMP_DIV;
  localparam int D_ELUTE = ELUTE_STR * 6 * PUMP_DIV;
  localparam int D_COLL  = COLL_STR * 6 * PUMP_DIV;
  localparam int D_MAX   = imax(imax(imax(D_BEAD, D_LYSIS),
                           imax(D_WASH, D_ELUTE)),
                           imax(imax(D_COLL, TRAP_CYC),
                           imax(FLUSH_CYC, 1)));
  localparam int DW = $clog2(D_MAX + 1);
  localparam int SW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_BEAD, S_LYSIS, S_TRAP, S_WASH,
    S_ELUTE, S_COLL, S_DONE, S_FLUSH
  } state_t;

  state_t        st, st_n;
  logic [DW-1:0] cnt, cnt_n, last;
  logic [SW-1:0] div, div_n;
  logic [2:0]    step, step_n;
  logic          ab_n;
  logic [CW-1:0] sel_n;

  function automatic logic [10:0] vpat(input state_t s);
    unique case (s)
      S_BEAD:  return 11'h53F;
      S_LYSIS: return 11'h7D6;
      S_TRAP:  return 11'h4FF;
      S_WASH:  return 11'h5BD;
      S_ELUTE: return 11'h5EB;
      S_COLL:  return 11'h2FF;
      default: return 11'h7FF;
    endcase
  endfunction

  function automatic logic [2:0] ppat(input logic [2:0] k);
    unique case (k)
      3'd0:    return 3'b011;
      3'd1:    return 3'b001;
      3'd2:    return 3'b101;
      3'd3:    return 3'b100;
      3'd4:    return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic pumping(input state_t s);
    return s == S_BEAD || s == S_LYSIS || s == S_WASH ||
           s == S_ELUTE || s == S_COLL;
  endfunction

  function automatic state_t after(input state_t s);
    unique case (s)
      S_BEAD:  return S_LYSIS;
      S_LYSIS: return S_TRAP;
      S_TRAP:  return S_WASH;
      S_WASH:  return S_ELUTE;
      S_ELUTE: return S_COLL;
      S_COLL:  return S_DONE;
      default: return S_IDLE;
    endcase
  endfunction

`ifdef MNACIDPRO_SEQ_FLUSH_EN
  state_t prev, prev_n;
`endif

  always_comb begin
    st_n  = st;
    ab_n  = 1'b0;
    last  = '0;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    prev_n = prev;
`endif
    unique case (st)
      S_BEAD:  last = DW'(D_BEAD - 1);
      S_LYSIS: last = DW'(D_LYSIS - 1);
      S_TRAP:  last = DW'(TRAP_CYC - 1);
      S_WASH:  last = DW'(D_WASH - 1);
      S_ELUTE: last = DW'(D_ELUTE - 1);
      S_COLL:  last = DW'(D_COLL - 1);
      S_FLUSH: last = DW'(FLUSH_CYC - 1);
      default: last = '0;
    endcase
    if (st == S_IDLE) begin
      if (start && !abort) st_n = S_BEAD;
    end else if (abort) begin
      st_n = S_IDLE;
      ab_n = 1'b1;
    end else if (cnt == last) begin
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      if (st == S_FLUSH) begin
        st_n = after(prev);
      end else if (pumping(st)) begin
        st_n   = S_FLUSH;
        prev_n = st;
      end else begin
        st_n = after(st);
      end
`else
      st_n = after(st);
`endif
    end
    // every state entry restarts duration, divider and pump step
    if (st_n != st || st == S_IDLE) begin
      cnt_n  = '0;
      div_n  = '0;
      step_n = '0;
    end else begin
      cnt_n  = cnt + DW'(1);
      div_n  = div + SW'(1);
      step_n = step;
      if (div == SW'(PUMP_DIV - 1)) begin
        div_n  = '0;
        step_n = (step == 3'd5) ? 3'd0 : step + 3'd1;
      end
    end
    sel_n = collect_sel;
    if (st == S_DONE && !ab_n)
      sel_n = (collect_sel == CW'(SIZE - 1)) ? '0
            : collect_sel + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      cnt         <= '0;
      div         <= '0;
      step        <= '0;
      valve       <= 11'h7FF;
      pump        <= 3'b111;
      collect_sel <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      div         <= div_n;
      step        <= step_n;
      valve       <= vpat(st_n);
      pump        <= pumping(st_n) ? ppat(step_n) : 3'b111;
      collect_sel <= sel_n;
      busy        <= st_n != S_IDLE;
      done        <= st_n == S_DONE;
      aborted     <= ab_n;
    end
  end

`ifdef MNACIDPRO_SEQ_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= S_IDLE;
      flush      <= '0;
      pump_flush <= '0;
    end else begin
      prev       <= prev_n;
      flush      <= (st_n == S_FLUSH) ? ~vpat(prev_n) : '0;
      pump_flush <= (st_n == S_FLUSH) ? 3'b111 : 3'b000;
    end
  end
`endif

endmodule

// File: tb/tb_mnacidpro_seq.sv
// tb_mnacidpro_seq: checks mnacidpro_seq against a per-cycle run script model.
// Directed scenarios followed by random start/abort traffic.
module tb_mnacidpro_seq;
  localparam int SIZE = 2;
  localparam int PD   = 4;
  localparam int BS   = 4;
  localparam int LS   = 8;
  localparam int WS   = 6;
  localparam int ES   = 4;
  localparam int CS   = 4;
  localparam int TC   = 16;
  localparam int FC   = 8;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  localparam int EXP_LEN  = 680;
  localparam int WASH_OFF = 320;
  localparam int LYS_AT   = 105;
`else
  localparam int EXP_LEN  = 640;
  localparam int WASH_OFF = 304;
  localparam int LYS_AT   = 97;
`endif

  localparam logic [10:0] VP [6] = '{11'h53F, 11'h7D6, 11'h4FF,
                                     11'h5BD, 11'h5EB, 11'h2FF};
  localparam int STR [6] = '{BS, LS, 0, WS, ES, CS};
  localparam logic [2:0] PP [6] = '{3'b011, 3'b001, 3'b101,
                                    3'b100, 3'b110, 3'b010};

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [10:0] valve;
  logic [2:0]  pump;
  logic [0:0]  collect_sel;
  logic        busy, done, aborted;
`ifdef MNACIDPRO_SEQ_FLUSH_EN
  logic [10:0] flush;
  logic [2:0]  pump_flush;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mnacidpro_seq #(
    .SIZE(SIZE), .PUMP_DIV(PD), .BEAD_STR(BS), .LYSIS_STR(LS),
    .WASH_STR(WS), .ELUTE_STR(ES), .COLL_STR(CS),
    .TRAP_CYC(TC), .FLUSH_CYC(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .valve(valve), .pump(pump), .collect_sel(collect_sel),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    , .flush(flush), .pump_flush(pump_flush)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  typedef struct packed {
    logic [10:0] v;
    logic [2:0]  p;
    logic        d;
    logic [10:0] f;
    logic [2:0]  pf;
  } item_t;

  item_t       q[$];
  logic [10:0] e_v, e_f;
  logic [2:0]  e_p, e_pf;
  logic        e_busy, e_done, e_ab;
  int          e_sel;

  // a run is a script of per-cycle outputs, one entry per clock
  task automatic build();
    for (int p = 0; p < 6; p++) begin
      if (p == 2) begin
        for (int i = 0; i < TC; i++)
          q.push_back('{VP[p], 3'b111, 1'b0, 11'h0, 3'b000});
      end else begin
        for (int i = 0; i < STR[p] * 6 * PD; i++)
          q.push_back('{VP[p], PP[(i / PD) % 6], 1'b0, 11'h0, 3'b000});
`ifdef MNACIDPRO_SEQ_FLUSH_EN
        for (int i = 0; i < FC; i++)
          q.push_back('{11'h7FF, 3'b111, 1'b0, ~VP[p], 3'b111});
`endif
      end
    end
    q.push_back('{11'h7FF, 3'b111, 1'b1, 11'h0, 3'b000});
  endtask

  task automatic go_idle();
    e_v = 11'h7FF; e_p = 3'b111; e_busy = 1'b0;
    e_f = '0; e_pf = '0;
  endtask

  task automatic pop();
    item_t it;
    it = q.pop_front();
    e_v = it.v; e_p = it.p; e_done = it.d;
    e_f = it.f; e_pf = it.pf; e_busy = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      go_idle();
      e_done = 1'b0; e_ab = 1'b0; e_sel = 0;
    end else begin
      e_done = 1'b0;
      e_ab   = 1'b0;
      if (!e_busy) begin
        if (start && !abort) begin
          build();
          pop();
        end
      end else if (abort) begin
        q.delete();
        e_ab = 1'b1;
        go_idle();
      end else if (q.size() > 0) begin
        pop();
      end else begin
        e_sel = (e_sel + 1) % SIZE;
        go_idle();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valve", 32'(valve), 32'(e_v));
      chk("pump", 32'(pump), 32'(e_p));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("aborted", 32'(aborted), 32'(e_ab));
      chk("sel", 32'(collect_sel), 32'(e_sel));
`ifdef MNACIDPRO_SEQ_FLUSH_EN
      chk("flush", 32'(flush), 32'(e_f));
      chk("pump_flush", 32'(pump_flush), 32'(e_pf));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_len(output int n);
    bit got;
    n = 0;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      tick();
      if (done) got = 1;
      else if (busy) n++;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valve", 32'(valve), 32'h7FF);
    chk("rst_pump", 32'(pump), 32'h7);
    chk("rst_sel", 32'(collect_sel), 0);
    repeat (100) tick();
    chk("idle_busy", 32'(busy), 0);

    start = 1'b1; tick(); start = 1'b0;
    chk("bead_valve", 32'(valve), 32'h53F);
    chk("bead_pump0", 32'(pump), 32'h3);
    repeat (4) tick();
    chk("bead_pump1", 32'(pump), 32'h1);
    repeat (92) tick();
`ifdef MNACIDPRO_SEQ_FLUSH_EN
    chk("flush_valve", 32'(valve), 32'h7FF);
    chk("flush_pat", 32'(flush), 32'h2C0);
    chk("flush_pump", 32'(pump_flush), 32'h7);
    repeat (8) tick();
`endif
    chk("lysis_valve", 32'(valve), 32'h7D6);
    run_len(n);
    chk("run1_len", 32'(LYS_AT + n), 32'(EXP_LEN));
    tick();
    chk("run1_sel", 32'(collect_sel), 1);
    chk("run1_done_off", 32'(done), 0);

    start = 1'b1; tick();
    run_len(n);
    start = 1'b0;
    chk("run2_len", 32'(1 + n), 32'(EXP_LEN));
    tick();
    chk("run2_sel", 32'(collect_sel), 0);

    start = 1'b1; tick(); start = 1'b0;
    repeat (WASH_OFF + 4) tick();
    chk("wash_valve", 32'(valve), 32'h5BD);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_valve", 32'(valve), 32'h7FF);
    chk("ab_pump", 32'(pump), 32'h7);
    chk("ab_pulse", 32'(aborted), 1);
    chk("ab_sel", 32'(collect_sel), 0);
    tick();
    chk("ab_pulse_off", 32'(aborted), 0);

    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);

    start = 1'b1; tick(); start = 1'b0;
    run_len(n);
    chk("run3_len", 32'(1 + n), 32'(EXP_LEN));
    tick();
    chk("run3_sel", 32'(collect_sel), 1);

    start = 1'b1; tick(); start = 1'b0;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valve", 32'(valve), 32'h7FF);
    chk("mrst_pump", 32'(pump), 32'h7);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_sel", 32'(collect_sel), 0);
    tick();
    rst_n = 1'b1;
    tick();

    repeat (6000) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
